// File: rtl/uart_pkg.sv
// Shared UART definitions: rx FSM state encoding, default bit timing, data width.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 87;  // 10 MHz core clock, 115200 baud
  localparam int DATA_W            = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Offset of the mid-bit sample point from the detected start edge.
  function automatic int half_bit(input int cpb);
    return (cpb - 1) / 2;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Purpose: multi-stage synchroniser for one asynchronous input, resets to 1 (idle line).
// Latency: STAGES clocks from pin to q.
// Backpressure: none; samples every clock.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_checked.sv
// Purpose: 8N1 UART receiver with glitch-rejecting start check, stop-bit check and one-byte output buffer.
// Latency: byte valid 3+H+9*CLKS_PER_BIT clocks after the pin's falling start edge is first captured.
// Backpressure: valid held until ready; a byte completing while the buffer is full is dropped and flagged as overrun.
module uart_rx_checked
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Rx_Serial,
  output logic [DATA_W-1:0] o_Rx_Byte,
  output logic              o_Rx_Valid,
  input  logic              i_Rx_Ready,
  output logic              o_Frame_Err,
  output logic              o_Overrun,
  input  logic              i_Err_Clr,
  output logic              o_Rx_Active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(half_bit(CLKS_PER_BIT));
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  rx_state_t         state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shift;
  logic              rx_s;
  logic              bit_end;
  logic              byte_done;
  logic              take;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Rst_n),
    .d     (i_Rx_Serial),
    .q     (rx_s)
  );

  assign bit_end   = (cnt == CNT_LAST);
  assign byte_done = (state == ST_STOP) && bit_end && rx_s;
  assign take      = o_Rx_Valid && i_Rx_Ready;

  // Receive FSM; o_Rx_Active tracks the state being entered so it stays registered.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      o_Frame_Err <= 1'b0;
      o_Rx_Active <= 1'b0;
    end else begin
      o_Frame_Err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state       <= ST_START;
            o_Rx_Active <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
            end else begin
              state       <= ST_IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            if (idx == IDX_LAST) begin
              state <= ST_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (rx_s) begin
              state       <= ST_IDLE;
              o_Rx_Active <= 1'b0;
            end else begin
              state       <= ST_BREAK;
              o_Frame_Err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          // A held-low line reports once; only a return to idle re-arms the receiver.
          if (rx_s) begin
            state       <= ST_IDLE;
            o_Rx_Active <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          cnt         <= '0;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

  // Output buffer: a same-cycle handshake frees the slot for the completing byte.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Rx_Byte  <= '0;
      o_Rx_Valid <= 1'b0;
      o_Overrun  <= 1'b0;
    end else begin
      if (byte_done && (!o_Rx_Valid || take)) begin
        o_Rx_Byte  <= shift;
        o_Rx_Valid <= 1'b1;
      end else if (take) begin
        o_Rx_Valid <= 1'b0;
      end

      if (byte_done && o_Rx_Valid && !take) begin
        o_Overrun <= 1'b1;
      end else if (i_Err_Clr) begin
        o_Overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_checked.sv
// Directed bench for uart_rx_checked: loopback timing, glitch, framing, overrun, reset and streaming.
module tb_uart_rx_checked;

  localparam int CPB = 87;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       rx_active;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  logic [7:0] rx_q[$];

  uart_rx_checked #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Rx_Serial (rx),
    .o_Rx_Byte   (rx_byte),
    .o_Rx_Valid  (rx_valid),
    .i_Rx_Ready  (rdy),
    .o_Frame_Err (frame_err),
    .o_Overrun   (overrun),
    .i_Err_Clr   (err_clr),
    .o_Rx_Active (rx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observer sits after the stimulus update so it sees the ready value for the coming edge.
  always @(posedge clk) begin
    #2;
    if (frame_err) fe_cnt++;
    if (rx_valid && rdy) rx_q.push_back(rx_byte);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int period);
    rx = 1'b0;
    ticks(period);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      ticks(period);
    end
    rx = stop;
    ticks(period);
  endtask

  task automatic consume();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    ticks(3);
    checks++; if (rx_byte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", rx_byte); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", rx_active); end
    rst_n = 1'b1;
    ticks(5);
    checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL idle_active got=%b exp=0", rx_active); end
  endtask

  // Start edge is captured at E0; valid must first appear just after E829.
  task automatic test_loopback();
    rdy = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, CPB);
      begin
        ticks(829);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL lb_valid_early got=%b exp=0", rx_valid); end
        checks++; if (rx_active !== 1'b1) begin failures++; $display("FAIL lb_active got=%b exp=1", rx_active); end
        tick();
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL lb_valid_e829 got=%b exp=1", rx_valid); end
        checks++; if (rx_byte !== 8'hA5) begin failures++; $display("FAIL lb_byte got=%h exp=a5", rx_byte); end
        checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL lb_active_end got=%b exp=0", rx_active); end
      end
    join
    ticks(20);
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL lb_valid_held got=%b exp=1", rx_valid); end
    consume();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL lb_valid_cleared got=%b exp=0", rx_valid); end
    checks++; if (rx_byte !== 8'hA5) begin failures++; $display("FAIL lb_byte_hold got=%h exp=a5", rx_byte); end
  endtask

  // 20-clock low pulse: start check at E46 finds the line high again.
  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    rx = 1'b0;
    ticks(20);
    rx = 1'b1;
    ticks(26);
    checks++; if (rx_active !== 1'b1) begin failures++; $display("FAIL gl_active_e45 got=%b exp=1", rx_active); end
    tick();
    checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL gl_active_e46 got=%b exp=0", rx_active); end
    ticks(900);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL gl_valid got=%b exp=0", rx_valid); end
    checks++; if (fe_cnt !== fe0) begin failures++; $display("FAIL gl_frame_err got=%0d exp=%0d", fe_cnt, fe0); end
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, CPB);
    ticks(2000);
    checks++; if (rx_active !== 1'b1) begin failures++; $display("FAIL fe_break_active got=%b exp=1", rx_active); end
    rx = 1'b1;
    ticks(10);
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL fe_pulses got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL fe_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL fe_active got=%b exp=0", rx_active); end
    send_frame(8'h55, 1'b1, CPB);
    ticks(5);
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL fe_next_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_byte !== 8'h55) begin failures++; $display("FAIL fe_next_byte got=%h exp=55", rx_byte); end
    consume();
  endtask

  task automatic test_overrun();
    rdy = 1'b0;
    send_frame(8'h11, 1'b1, CPB);
    send_frame(8'h22, 1'b1, CPB);
    ticks(5);
    checks++; if (rx_byte !== 8'h11) begin failures++; $display("FAIL ov_byte got=%h exp=11", rx_byte); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ov_flag got=%b exp=1", overrun); end
    ticks(50);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ov_sticky got=%b exp=1", overrun); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ov_clear got=%b exp=0", overrun); end
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ov_valid_kept got=%b exp=1", rx_valid); end
    consume();
    // Same sequence, but the consumer takes 0x11 on the very edge 0x22 completes.
    send_frame(8'h11, 1'b1, CPB);
    fork
      send_frame(8'h22, 1'b1, CPB);
      begin
        ticks(829);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        checks++; if (rx_byte !== 8'h22) begin failures++; $display("FAIL hs_byte got=%h exp=22", rx_byte); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL hs_valid got=%b exp=1", rx_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL hs_overrun got=%b exp=0", overrun); end
      end
    join
    consume();
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0;
    send_frame(8'h5A, 1'b1, CPB);
    send_frame(8'h66, 1'b1, CPB);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL rm_pre_overrun got=%b exp=1", overrun); end
    // 0xFF: start bit, then the line stays high; stop 40 clocks into data bit 4.
    rx = 1'b0;
    ticks(CPB);
    rx = 1'b1;
    ticks(4 * CPB + 40);
    checks++; if (rx_active !== 1'b1) begin failures++; $display("FAIL rm_pre_active got=%b exp=1", rx_active); end
    rst_n = 1'b0;
    #2;
    checks++; if (rx_byte !== 8'h00) begin failures++; $display("FAIL rm_byte got=%h exp=00", rx_byte); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", rx_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rm_overrun got=%b exp=0", overrun); end
    checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL rm_active got=%b exp=0", rx_active); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rm_frame_err got=%b exp=0", frame_err); end
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    send_frame(8'h81, 1'b1, CPB);
    ticks(5);
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL rm_next_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_byte !== 8'h81) begin failures++; $display("FAIL rm_next_byte got=%h exp=81", rx_byte); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rm_next_overrun got=%b exp=0", overrun); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [7:0] tbl [16];
    int base;
    int fe0;
    tbl = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A, 8'hA5, 8'h3C, 8'hC3,
            8'h7E, 8'h81, 8'h12, 8'h34, 8'hFE, 8'h7F, 8'h96, 8'h69};
    fe0  = fe_cnt;
    base = rx_q.size();
    rdy  = 1'b1;
    ticks(5);
    for (int i = 0; i < 16; i++) begin
      send_frame(tbl[i], 1'b1, (i < 8) ? 89 : 85);
    end
    ticks(10);
    rdy = 1'b0;
    checks++; if (rx_q.size() - base !== 16) begin failures++; $display("FAIL st_count got=%0d exp=16", rx_q.size() - base); end
    for (int i = 0; i < 16; i++) begin
      if (base + i < rx_q.size()) begin
        checks++;
        if (rx_q[base + i] !== tbl[i]) begin
          failures++;
          $display("FAIL st_byte%0d got=%h exp=%h", i, rx_q[base + i], tbl[i]);
        end
      end
    end
    checks++; if (fe_cnt !== fe0) begin failures++; $display("FAIL st_frame_err got=%0d exp=%0d", fe_cnt, fe0); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL st_overrun got=%b exp=0", overrun); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL st_valid got=%b exp=0", rx_valid); end
  endtask

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    rdy     = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_loopback();
    ticks(10);
    test_glitch();
    test_frame_err();
    ticks(10);
    test_overrun();
    ticks(10);
    test_reset_mid();
    ticks(10);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
